serial_subt: RTL and testbench
==============================

SERIAL_SUBT -- requirements
Module: serial_subt

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result bit count (legal range 2..32).
REQ-002 SHALL provide clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide start  input  1  request to begin one subtraction; sampled on rising clk edges.
REQ-005 SHALL provide a  input  WIDTH  minuend; sampled only on the accepting start edge.
REQ-006 SHALL provide b  input  WIDTH  subtrahend; sampled only on the accepting start edge.
REQ-007 SHALL provide bin  input  1  borrow-in; sampled only on the accepting start edge.
REQ-008 SHALL provide busy  output  1  high while bits are being processed.
REQ-009 SHALL provide done  output  1  one-cycle pulse marking a new valid result.
REQ-010 SHALL provide d  output  WIDTH  difference a-b-bin, modulo 2^WIDTH.
REQ-011 SHALL provide bo  output  1  final borrow-out.
REQ-012 SHALL provide ovf  output  1  signed overflow; present only when SERIAL_SUBT_OVF_EN is defined.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE.
REQ-014 IDLE: start=1 SHALL latch a, b and bin into internal registers, clear the bit counter, and move to SHIFT; start=0 SHALL stay in IDLE.
REQ-015 SHIFT: each edge SHALL process exactly one bit, LSB first: di = ai ^ bi ^ br; br_next = (~ai & bi) | (~ai & br) | (bi & br); br = bin for bit 0.
REQ-016 SHIFT: di SHALL shift into an internal result register from the MSB side, so bit i lands at position i after WIDTH edges.
REQ-017 Timing: call the accepting start edge E0. Edges E1..EW SHALL process bits 0..WIDTH-1. At EW, d and bo SHALL load from the internal registers and the state SHALL move to DONE.
REQ-018 busy SHALL be 1 from after E0 until EW; it SHALL be 0 in IDLE and DONE.
REQ-019 done SHALL be 1 only in DONE, for exactly one cycle (between EW and EW+1).
REQ-020 DONE: start=1 SHALL be accepted exactly as in IDLE (back-to-back, next state SHIFT); otherwise the next state SHALL be IDLE.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 d, bo (and ovf) SHALL change only at EW and hold their value until the next EW or reset.
REQ-023 Changes on a, b or bin after E0 SHALL NOT affect the result.
REQ-024 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, busy=0, done=0, d=0, bo=0, ovf=0, counter=0, internal operand/borrow/result registers=0.
REQ-026 Reset mid-operation SHALL discard the partial result; no done SHALL follow for that operation.
REQ-027 Release of rst SHALL NOT by itself start an operation; start is required.

Configuration
REQ-028 Macro SERIAL_SUBT_OVF_EN defined: ovf port SHALL exist and load at EW with (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), using the latched operands.
REQ-029 Macro SERIAL_SUBT_OVF_EN undefined: ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-030 SHALL check a=0x35, b=0x12, bin=0, start pulse -> busy for 8 cycles, then done pulse, d=0x23, bo=0.
REQ-031 SHALL check a=0x00, b=0x01, bin=0 -> d=0xFF, bo=1, ovf=0.
REQ-032 SHALL check a=0x80, b=0x01, bin=0 with SERIAL_SUBT_OVF_EN -> d=0x7F, bo=0, ovf=1.
REQ-033 SHALL check a=0x10, b=0x0F, bin=1 -> d=0x00, bo=0; then start held high through DONE with a=0x05, b=0x03 -> second done exactly 9 cycles after the first, d=0x02.
REQ-034 SHALL check start re-asserted at cycle 3 of busy with different operands -> ignored; first result correct.
REQ-035 SHALL check rst asserted at cycle 4 of busy -> all outputs 0 immediately, state IDLE, no done pulse before the next start.

Source files
------------

// File: rtl/serial_subt.sv
// serial_subt: bit-serial subtractor, d = a - b - bin (mod 2^WIDTH), LSB first.
//   A start edge in IDLE or DONE latches the operands. WIDTH SHIFT edges then
//   process one bit each. The last of these edges loads d and bo, and also ovf
//   when the overflow output is enabled.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - begin a subtraction (ignored while busy)
//   a, b  - minuend / subtrahend, sampled on the accepting start edge
//   bin   - borrow-in, sampled on the accepting start edge
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when a new result is available
//   d, bo - difference and final borrow-out, held until the next result
//   ovf   - signed overflow (only when SERIAL_SUBT_OVF_EN is defined)
// Build option: define SERIAL_SUBT_OVF_EN to add the ovf output and its logic.
module serial_subt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUBT_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             ai, bi, di, br_nx;
`ifdef SERIAL_SUBT_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUBT_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUBT_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // The operand registers rotate right instead of shifting. On the final
  // edge, bit 0 then holds the original MSB, which feeds the overflow term.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUBT_OVF_EN
    ovf_d   = ovf_q;
`endif
    ai      = a_q[0];
    bi      = b_q[0];
    di      = ai ^ bi ^ br_q;
    br_nx   = (~ai & bi) | (~ai & br_q) | (bi & br_q);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = {a_q[0], a_q[WIDTH-1:1]};
        b_d   = {b_q[0], b_q[WIDTH-1:1]};
        br_d  = br_nx;
        res_d = {di, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          d_d     = {di, res_q[WIDTH-1:1]};
          bo_d    = br_nx;
`ifdef SERIAL_SUBT_OVF_EN
          ovf_d   = (ai != bi) & (di != ai);
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;
`ifdef SERIAL_SUBT_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subt.sv
module tb_serial_subt;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done, bo;
  logic [7:0] d;
`ifdef SERIAL_SUBT_OVF_EN
  logic       ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_subt #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
`ifdef SERIAL_SUBT_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_d;
    logic       exp_bo;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                       output logic [7:0] md, output logic mbo, output logic movf);
    int diff, sdiff;
    diff  = int'(ma) - int'(mb) - int'(mbin);
    sdiff = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    md    = diff[7:0];
    mbo   = (diff < 0);
    movf  = (sdiff < -128) || (sdiff > 127);
  endtask

  // Issue one start, scramble the inputs right after acceptance, then count
  // busy cycles until done (bounded). Returns at the negedge where done=1.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                       output int busy_cnt, output bit got);
    busy_cnt = 0;
    got      = 0;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  vec_t vecs[7];

  initial begin
    int         bc, n, seen;
    bit         got;
    logic [7:0] md;
    logic       mbo, movf;
    logic [7:0] ra, rb;
    logic       rbin;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_bo", bo, 0);
`ifdef SERIAL_SUBT_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("no_start_after_rst", seen, 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, bc, got);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 8);
      chk($sformatf("vec%0d_d", i), d, vecs[i].exp_d);
      chk($sformatf("vec%0d_bo", i), bo, vecs[i].exp_bo);
`ifdef SERIAL_SUBT_OVF_EN
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
`endif
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // Back-to-back: start held through DONE.
    do_op(8'h10, 8'h0F, 1'b1, bc, got);
    chk("b2b_first_d", d, 8'h00);
    chk("b2b_first_bo", bo, 0);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        n = i;
        break;
      end
    end
    chk("b2b_done_spacing", n, 9);
    chk("b2b_second_d", d, 8'h02);
    chk("b2b_second_bo", bo, 0);
    @(negedge clk);
    chk("b2b_back_idle", {busy, done}, 2'b00);

    // Start re-asserted during busy cycle 3 must be ignored.
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (busy) bc++;
      if (bc == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h11; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_got_done", got, 1);
    chk("ign_busy_cycles", bc, 8);
    chk("ign_d", d, 8'h23);
    chk("ign_bo", bo, 0);
    @(negedge clk);
    chk("ign_no_restart", {busy, done}, 2'b00);

    // Reset at busy cycle 4.
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    for (int i = 0; i < 20 && bc < 4; i++) begin
      if (busy) bc++;
      if (bc < 4) @(negedge clk);
    end
    chk("rst_mid_reached", bc, 4);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_d", d, 0);
    chk("rst_mid_bo", bo, 0);
`ifdef SERIAL_SUBT_OVF_EN
    chk("rst_mid_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("rst_mid_no_done", seen, 0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbin = 1'b1; end
      model(ra, rb, rbin, md, mbo, movf);
      do_op(ra, rb, rbin, bc, got);
      chk($sformatf("rnd%0d_busy", i), bc, 8);
      chk($sformatf("rnd%0d_d(%0h-%0h-%0d)", i, ra, rb, rbin), d, md);
      chk($sformatf("rnd%0d_bo", i), bo, mbo);
`ifdef SERIAL_SUBT_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), ovf, movf);
`endif
      if (i % 4 == 0) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_hold_d", i), d, md);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
